// File: rtl/spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spi_txn_arbiter
//  Description : Round-robin arbiter/sequencer that shares one SPI master
//                between NUM_REQ requesters. A selected requester's tx word
//                is latched and a one-cycle start pulse is issued to the
//                master. When the master reports completion, the received
//                word is returned with a one-cycle done pulse to the
//                requester that was served.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    NUM_REQ      number of requesters (>= 2)
//    Data_width   SPI word width, must match the SPI master
//    TIMEOUT_CYC  WAIT-state cycle limit (only with SPI_ARB_TIMEOUT_EN)
//  Optional feature macro
//    SPI_ARB_TIMEOUT_EN  enables the WAIT-state watchdog; without it the
//                        arbiter waits indefinitely and o_timeout is 0
//  Ports
//    clk         in   system clock, rising edge
//    rst         in   asynchronous active-high reset
//    i_req       in   [NUM_REQ]   request level per requester
//    i_req_data  in   [NUM_REQ*Data_width] packed tx words, req k at
//                     [k*Data_width +: Data_width]
//    o_grant     out  [NUM_REQ]   one-hot grant, START through DONE
//    o_done      out  [NUM_REQ]   one-cycle completion pulse
//    o_rx_data   out  [Data_width] received word, held until next DONE
//    o_busy      out  high in any state other than IDLE
//    o_timeout   out  one-cycle watchdog-abort pulse alongside o_done
//    m_start     out  one-cycle start pulse to SPI master
//    m_tx_data   out  [Data_width] word to SPI master
//    m_done      in   SPI master transfer complete
//    m_rx_data   in   [Data_width] word received by SPI master
// ============================================================================
module spi_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int Data_width  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*Data_width-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_done,
    output logic [Data_width-1:0]         o_rx_data,
    output logic                          o_busy,
    output logic                          o_timeout,
    output logic                          m_start,
    output logic [Data_width-1:0]         m_tx_data,
    input  logic                          m_done,
    input  logic [Data_width-1:0]         m_rx_data
);

    localparam int                 c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_one   = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_ptr_w-1:0]   r_ptr;   // last requester served
    logic [c_ptr_w-1:0]   r_idx;   // requester currently being served

    logic [Data_width-1:0] w_req_words [NUM_REQ];
    logic                  w_found;
    logic [c_ptr_w-1:0]    w_sel;
    logic [c_ptr_w-1:0]    w_cand;
    int                    w_cand_int;
    logic [NUM_REQ-1:0]    w_sel_onehot;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam logic [31:0] c_tmo_last = 32'(TIMEOUT_CYC - 1);
    logic [31:0]            r_wait_cnt;
    logic                   r_timeout;
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    // Unpack the flat tx-word bus into one word per requester
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_req_words[g] = i_req_data[g*Data_width +: Data_width];
    end

    // Round-robin search: start one past the last served requester and wrap,
    // so the requester just served is the last one considered.
    always_comb begin
        w_found    = 1'b0;
        w_sel      = r_ptr;
        w_cand     = '0;
        w_cand_int = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand_int = int'(r_ptr) + i;
            if (w_cand_int >= NUM_REQ) begin
                w_cand_int = w_cand_int - NUM_REQ;
            end
            w_cand = c_ptr_w'(w_cand_int);
            if (!w_found && i_req[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_sel_onehot = c_one << w_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= c_ptr_w'(NUM_REQ - 1);
            r_idx     <= '0;
            o_grant   <= '0;
            o_done    <= '0;
            o_rx_data <= '0;
            o_busy    <= 1'b0;
            m_start   <= 1'b0;
            m_tx_data <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Outputs for START are set here so they appear
                    // registered in the START cycle itself.
                    if (w_found) begin
                        r_idx     <= w_sel;
                        m_tx_data <= w_req_words[w_sel];
                        m_start   <= 1'b1;
                        o_grant   <= w_sel_onehot;
                        o_busy    <= 1'b1;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    // m_done is deliberately not looked at here
                    m_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (m_done) begin
                        o_rx_data <= m_rx_data;
                        o_done    <= o_grant;
                        r_state   <= ST_DONE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    // Counter holds the number of completed WAIT cycles, so
                    // the last permitted cycle is TIMEOUT_CYC-1. A real
                    // m_done in that cycle wins via the branch above.
                    else if (r_wait_cnt == c_tmo_last) begin
                        o_rx_data <= '0;
                        o_done    <= o_grant;
                        r_timeout <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
`endif
                end
                ST_DONE: begin
                    o_done  <= '0;
                    o_grant <= '0;
                    o_busy  <= 1'b0;
                    r_ptr   <= r_idx;
`ifdef SPI_ARB_TIMEOUT_EN
                    r_timeout <= 1'b0;
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_txn_arbiter
//  Description : Self-checking bench for spi_txn_arbiter. A table of
//                directed transactions with hand-computed grants and data,
//                plus hand-written sequences for continuous requests,
//                reset during WAIT and (with SPI_ARB_TIMEOUT_EN) watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_txn_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 8;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int c_d0 = 12;
`else
    localparam int c_d0 = 20;
`endif
    // requester words: req0=B0, req1=A5, req2=C2, req3=D3
    localparam logic [NUM_REQ*DW-1:0] c_words = {8'hD3, 8'hC2, 8'hA5, 8'hB0};

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      i_req;
    logic [NUM_REQ*DW-1:0]   i_req_data;
    logic [NUM_REQ-1:0]      o_grant;
    logic [NUM_REQ-1:0]      o_done;
    logic [DW-1:0]           o_rx_data;
    logic                    o_busy;
    logic                    o_timeout;
    logic                    m_start;
    logic [DW-1:0]           m_tx_data;
    logic                    m_done;
    logic [DW-1:0]           m_rx_data;

    int n_cmp = 0;
    int n_err = 0;

    // master model controls
    int         model_delay = 1;
    logic [7:0] model_word  = 8'h00;
    bit         model_on    = 1'b1;
    bit         early_pulse = 1'b0;
    int         model_cnt   = 0;

    spi_txn_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .Data_width  (DW),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_req_data (i_req_data),
        .o_grant    (o_grant),
        .o_done     (o_done),
        .o_rx_data  (o_rx_data),
        .o_busy     (o_busy),
        .o_timeout  (o_timeout),
        .m_start    (m_start),
        .m_tx_data  (m_tx_data),
        .m_done     (m_done),
        .m_rx_data  (m_rx_data)
    );

    always #5 clk = ~clk;

    // Behavioural SPI master: m_done is high during WAIT cycle number
    // model_delay (1-based). Optionally a bogus m_done is raised during START.
    always @(negedge clk) begin
        m_done = 1'b0;
        if (rst) begin
            model_cnt = 0;
        end else if (m_start) begin
            model_cnt = model_delay;
            if (early_pulse) begin
                m_done    = 1'b1;
                m_rx_data = 8'hEE;
            end
        end else if (model_cnt > 0) begin
            if (model_cnt == 1 && model_on) begin
                m_done    = 1'b1;
                m_rx_data = model_word;
            end
            model_cnt = model_cnt - 1;
        end
    end

    typedef struct {
        logic [3:0] req;
        int         delay;
        logic [7:0] word;
        bit         on;
        bit         early;
        bit         drop;
        logic [3:0] exp_grant;
        logic [7:0] exp_tx;
        logic [7:0] exp_rx;
        bit         exp_to;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One transaction starting from IDLE at a negedge; ends in IDLE at a negedge.
    task automatic run_txn(input vec_t v);
        int n;
        int bad;
        bit seen;
        i_req       = v.req;
        model_delay = v.delay;
        model_word  = v.word;
        model_on    = v.on;
        early_pulse = v.early;
        n = 0; seen = 1'b0;
        while (!seen && n < 8) begin
            @(negedge clk);
            n++;
            seen = m_start;
        end
        check("start_latency", n, 1);
        check("grant_at_start", o_grant, v.exp_grant);
        check("tx_at_start", m_tx_data, v.exp_tx);
        check("busy_at_start", o_busy, 1);
        if (v.drop) begin
            i_req      = '0;
            i_req_data = ~c_words;
        end
        n = 0; seen = 1'b0; bad = 0;
        while (!seen && n < v.delay + 20) begin
            @(negedge clk);
            n++;
            if (o_done != 0) seen = 1'b1;
            else if (m_start !== 1'b0 || o_grant !== v.exp_grant ||
                     m_tx_data !== v.exp_tx || o_busy !== 1'b1) bad++;
        end
        check("wait_phase_errors", bad, 0);
        check("done_latency", n, v.delay + 1);
        check("done_pulse", o_done, v.exp_grant);
        check("rx_data", o_rx_data, v.exp_rx);
        check("timeout_flag", o_timeout, v.exp_to);
        check("grant_in_done", o_grant, v.exp_grant);
        check("tx_in_done", m_tx_data, v.exp_tx);
        i_req       = '0;
        i_req_data  = c_words;
        early_pulse = 1'b0;
        @(negedge clk);
        check("idle_after_done", {o_done, o_grant, o_busy, m_start, o_timeout}, 0);
        check("rx_held", o_rx_data, v.exp_rx);
    endtask

    // Requests held by caller; observes n back-to-back transactions.
    // exp_seq holds the expected one-hot grant of transaction t at [t*4 +: 4].
    task automatic watch(input int n, input logic [31:0] exp_seq);
        int  cyc;
        int  last;
        int  multi;
        bit  found;
        cyc = 0; last = 0; multi = 0;
        for (int t = 0; t < n; t++) begin
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge clk);
                cyc++;
                if ($countones(o_grant) > 1) multi++;
                if (m_start) found = 1'b1;
            end
            check("rr_start_seen", found, 1);
            check("rr_grant_order", o_grant, exp_seq[t*4 +: 4]);
            if (t > 0) check("rr_start_gap_ge4", (cyc - last) >= 4, 1);
            last = cyc;
            found = 1'b0;
            for (int c = 0; c < 20 && !found; c++) begin
                @(negedge clk);
                cyc++;
                if ($countones(o_grant) > 1) multi++;
                if (o_done != 0) found = 1'b1;
            end
            check("rr_done_seen", found, 1);
            check("rr_done_onehot", o_done, exp_seq[t*4 +: 4]);
        end
        check("rr_grant_onehot", multi, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got timeout, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t tbl [8];
        int   k;
        //           req      dly   word   on  er  dr  grant    tx     rx     to
        tbl[0] = '{4'b0010, c_d0, 8'h3C, 1, 0, 0, 4'b0010, 8'hA5, 8'h3C, 0};
        tbl[1] = '{4'b1111, 1,    8'h11, 1, 0, 0, 4'b0100, 8'hC2, 8'h11, 0};
        tbl[2] = '{4'b0011, 2,    8'h22, 1, 0, 0, 4'b0001, 8'hB0, 8'h22, 0};
        tbl[3] = '{4'b1000, 3,    8'h33, 1, 1, 0, 4'b1000, 8'hD3, 8'h33, 0};
        tbl[4] = '{4'b1001, 1,    8'h44, 1, 0, 0, 4'b0001, 8'hB0, 8'h44, 0};
        tbl[5] = '{4'b1001, 1,    8'h45, 1, 0, 0, 4'b1000, 8'hD3, 8'h45, 0};
        tbl[6] = '{4'b0100, 5,    8'h55, 1, 0, 1, 4'b0100, 8'hC2, 8'h55, 0};
        tbl[7] = '{4'b0110, 2,    8'h66, 1, 0, 0, 4'b0010, 8'hA5, 8'h66, 0};

        rst        = 1'b1;
        i_req      = '0;
        i_req_data = c_words;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {o_grant, o_done, o_rx_data, o_busy, o_timeout, m_start, m_tx_data}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_no_request", {o_busy, m_start}, 0);

        for (k = 0; k < 8; k++) begin
            run_txn(tbl[k]);
        end

        // req0 and req2 held continuously: strict alternation 2,0,2,0
        model_delay = 1; model_on = 1'b1;
        i_req = 4'b0101;
        watch(4, 32'h0000_1414);
        i_req = '0;
        @(negedge clk);

        // reset during WAIT for req3
        model_delay = 20;
        i_req = 4'b1000;
        k = 0;
        while (!m_start && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("rst_test_grant", o_grant, 4'b1000);
        repeat (3) @(negedge clk);
        check("rst_test_in_wait", {o_busy, o_grant}, 5'b1_1000);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {o_grant, o_done, o_rx_data, o_busy, o_timeout, m_start, m_tx_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        model_delay = 1;
        i_req = 4'b1111;
        watch(5, 32'h0001_8421);
        i_req = '0;
        @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{4'b0100, 16, 8'h77, 0, 0, 0, 4'b0100, 8'hC2, 8'h00, 1};
            run_txn(tv);
            tv = '{4'b0100, 16, 8'h5A, 1, 0, 0, 4'b0100, 8'hC2, 8'h5A, 0};
            run_txn(tv);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
